// File: rtl/bus_memory.sv
// bus_memory: single-port word memory behind a valid/ready request channel and
// an in-order valid/ready response channel with a fixed LATENCY of 1..4.
module bus_memory #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic                i_req_we,
    input  logic [DATA_W/8-1:0] i_req_be,
    input  logic [DATA_W-1:0]   i_req_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(BE_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned HI_LSB = OFF_W + IDX_W;
    localparam int unsigned Q_N    = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned AGE_W  = 2;

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [PTR_W-1:0]  LAT_PTR  = PTR_W'(LATENCY - 1);
    localparam logic [AGE_W-1:0]  LAT_AGE  = AGE_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]  LAT_CNT  = CNT_W'(LATENCY);

    // Reject unsupported latencies at elaboration.
    if (LATENCY < 1 || LATENCY > 4) begin : g_lat_check
        $error("bus_memory: LATENCY must be in 1..4");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Response queue: slots are shared by the latency pipeline and the
    // backpressure buffer; an entry becomes presentable once its age
    // reaches LATENCY-1, and outstanding never exceeds LATENCY.
    logic [DATA_W-1:0] r_q_data [Q_N];
    logic              r_q_err  [Q_N];
    logic [AGE_W-1:0]  r_q_age  [Q_N];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_err;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rsp_rdata;
    logic              w_head_due;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == LAT_PTR) ? '0 : p + 1'b1;
    endfunction

    // Address decode and error classification.
    assign w_misaligned   = |(i_req_addr & LOW_MASK);
    assign w_out_of_range = |(i_req_addr >> HI_LSB);
    assign w_err          = w_misaligned | w_out_of_range;
    assign w_idx          = i_req_addr[OFF_W +: IDX_W];
    assign w_rsp_rdata    = (!i_req_we && !w_err) ? r_mem[w_idx] : '0;

    // Handshakes and outputs; everything is forced quiet while in reset.
    assign w_head_due  = (r_count != '0) && (r_q_age[r_rd_ptr] == LAT_AGE);
    assign o_rsp_valid = !i_rst && w_head_due;
    assign o_rsp_rdata = o_rsp_valid ? r_q_data[r_rd_ptr] : '0;
    assign o_rsp_err   = o_rsp_valid && r_q_err[r_rd_ptr];
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    assign o_req_ready = !i_rst && ((r_count < LAT_CNT) || w_pop);
    assign w_push      = i_req_valid && o_req_ready;

    // Byte-lane writes commit on the accept edge; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_push && i_req_we && !w_err) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_req_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Queue pointers and outstanding count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Queue payload and per-entry age; new entries start at age zero.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < Q_N; i++) begin
            if (r_q_age[i] != LAT_AGE) begin
                r_q_age[i] <= r_q_age[i] + 1'b1;
            end
        end
        if (w_push) begin
            r_q_age[r_wr_ptr]  <= '0;
            r_q_data[r_wr_ptr] <= w_rsp_rdata;
            r_q_err[r_wr_ptr]  <= w_err;
        end
    end

endmodule

// File: doc/bus_memory.md
BUS_MEMORY -- requirements
Module: bus_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits; power of two, >= 8.
REQ-002 SHALL have parameter DEPTH, default 1024: number of words; power of two.
REQ-003 SHALL have parameter ADDR_W, default 32: byte-address width; >= log2(DEPTH) + log2(DATA_W/8).
REQ-004 SHALL have parameter LATENCY, default 1: accept-to-response cycles, legal range 1..4; elaboration error outside it.
REQ-005 SHALL have port i_clk, input, 1: sole clock; all state updates on rising edge.
REQ-006 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port i_req_valid, input, 1: request present.
REQ-008 SHALL have port o_req_ready, output, 1: request accepted this cycle if valid.
REQ-009 SHALL have port i_req_addr, input, ADDR_W: byte address.
REQ-010 SHALL have port i_req_we, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port i_req_be, input, DATA_W/8: byte-lane write enables.
REQ-012 SHALL have port i_req_wdata, input, DATA_W: write data.
REQ-013 SHALL have port o_rsp_valid, output, 1: response present.
REQ-014 SHALL have port i_rsp_ready, input, 1: response consumed this cycle if valid.
REQ-015 SHALL have port o_rsp_rdata, output, DATA_W: read data.
REQ-016 SHALL have port o_rsp_err, output, 1: request was misaligned or out of range.

Function
REQ-017 SHALL accept a request on a rising edge where i_req_valid && o_req_ready; one request per cycle max.
REQ-018 SHALL decode word index = i_req_addr[log2(DATA_W/8) +: log2(DEPTH)].
REQ-019 SHALL flag error when the low log2(DATA_W/8) address bits are nonzero (misaligned) or any bit above the word-index field is nonzero (out of range).
REQ-020 SHALL, for an accepted error-free write, update only the lanes with i_req_be set, committed on the accept edge; be = 0 writes nothing but still responds.
REQ-021 SHALL, for an accepted erroneous request, leave memory unchanged and respond with o_rsp_err = 1, o_rsp_rdata = 0.
REQ-022 SHALL return full-word data for reads; write responses carry o_rsp_rdata = 0, o_rsp_err per REQ-019.
REQ-023 SHALL return a read accepted one edge after a write to the same word with the new data (no stale read).
REQ-024 SHALL produce exactly one response per accepted request, strictly in acceptance order.
REQ-025 SHALL, with i_rsp_ready held high, assert o_rsp_valid for a request exactly LATENCY edges after its accept edge.
REQ-026 SHALL hold o_rsp_valid, o_rsp_rdata and o_rsp_err stable while o_rsp_valid && !i_rsp_ready.
REQ-027 SHALL buffer responses in an in-order queue of LATENCY entries behind the LATENCY-stage read pipeline; no response is ever dropped or duplicated.
REQ-028 SHALL track outstanding = accepted minus consumed (range 0..LATENCY) and drive o_req_ready = (outstanding < LATENCY) || (o_rsp_valid && i_rsp_ready).
REQ-029 SHALL sustain one request and one response per cycle indefinitely when i_rsp_ready is held high.
REQ-030 SHALL, on a simultaneous accept and consume with outstanding = LATENCY, keep outstanding at LATENCY.
REQ-031 SHALL leave o_req_ready independent of i_req_valid.

Reset
REQ-032 SHALL, while i_rst = 1, drive o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rdata = 0, o_req_ready = 0, and accept nothing.
REQ-033 SHALL, on reset, clear the pipeline, response queue and outstanding count; in-flight requests produce no response.
REQ-034 SHALL NOT clear memory contents on reset; writes committed before reset persist.
REQ-035 SHALL drive o_req_ready = 1 on the first cycle after i_rst deasserts.

Verification
REQ-036 SHALL verify: LATENCY=1, write 0xDEADBEEF be=0xF addr 0x10, then read 0x10 -> rsp 1 cycle after each accept; read data 0xDEADBEEF, err 0.
REQ-037 SHALL verify: word 0x20 = 0x11223344, write 0xAABBCCDD be=0x5 -> read 0x20 returns 0x11BB33DD.
REQ-038 SHALL verify: read 0x13 (misaligned) and read 0x1000 (DEPTH=1024, out of range) -> both err 1, rdata 0, memory unchanged.
REQ-039 SHALL verify: LATENCY=3, i_rsp_ready low 10 cycles, valid high -> exactly 3 accepted, o_req_ready 0 after; release -> 3 in-order responses, then back-to-back flow.
REQ-040 SHALL verify: LATENCY=2, 2 reads outstanding, i_rst pulsed 1 cycle -> no responses emerge, o_req_ready = 1 next cycle, earlier writes still readable.
REQ-041 SHALL verify: i_rsp_ready high, 100 back-to-back random read/write requests -> one response per cycle after LATENCY fill, matching a reference model.
